// File: rtl/calc1_port_scheduler.sv
// Four-port request capture with round-robin sharing of one calc1 ALU over valid/ready/done.
// Define CALC1_SCHED_TIMEOUT_EN to add a watchdog that fails an operation lacking alu_done.
module calc1_port_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [0:3]  alu_cmd,
    output logic [0:31] alu_op1,
    output logic [0:31] alu_op2,
    input  logic        alu_done,
    input  logic [0:31] alu_result,
    input  logic [0:1]  alu_resp
);

    typedef enum logic [1:0] {PIdle, POp2, PPend, PResp} port_st_e;
    typedef enum logic [1:0] {SIdle, SReq, SWait} sched_st_e;

    logic [3:0]  cmd_in   [4];
    logic [31:0] data_in  [4];
    logic [1:0]  resp_out [4];
    logic [31:0] data_out [4];

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out_resp1 = resp_out[0];
    assign out_resp2 = resp_out[1];
    assign out_resp3 = resp_out[2];
    assign out_resp4 = resp_out[3];
    assign out_data1 = data_out[0];
    assign out_data2 = data_out[1];
    assign out_data3 = data_out[2];
    assign out_data4 = data_out[3];

    port_st_e    pst_q   [4];
    port_st_e    pst_d   [4];
    logic [3:0]  cmd_q   [4];
    logic [3:0]  cmd_d   [4];
    logic [31:0] op1_q   [4];
    logic [31:0] op1_d   [4];
    logic [31:0] op2_q   [4];
    logic [31:0] op2_d   [4];
    logic [1:0]  resp_q  [4];
    logic [1:0]  resp_d  [4];
    logic [31:0] rdata_q [4];
    logic [31:0] rdata_d [4];

    sched_st_e   sst_q, sst_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  alu_cmd_q, alu_cmd_d;
    logic [31:0] alu_op1_q, alu_op1_d;
    logic [31:0] alu_op2_q, alu_op2_d;

    logic [3:0]  pend;
    logic        gnt_found;
    logic [1:0]  gnt_sel;
    logic        fin;
    logic [1:0]  fin_resp;
    logic [31:0] fin_data;

`ifdef CALC1_SCHED_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    function automatic logic cmd_is_valid(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // A port latching a valid operand 2 counts as pending so alu_valid can rise in cycle 2.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pend[i] = (pst_q[i] == PPend) || ((pst_q[i] == POp2) && cmd_is_valid(cmd_q[i]));
        end
    end

    // Scan from the highest offset down so the nearest pending port at/after ptr_q wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (pend[ptr_q + 2'(k)]) begin
                gnt_found = 1'b1;
                gnt_sel   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        sst_d     = sst_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        alu_cmd_d = alu_cmd_q;
        alu_op1_d = alu_op1_q;
        alu_op2_d = alu_op2_q;
        fin       = 1'b0;
        fin_resp  = alu_resp;
        fin_data  = alu_result;
`ifdef CALC1_SCHED_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (sst_q)
            SIdle: begin
                if (gnt_found) begin
                    sst_d     = SReq;
                    gnt_d     = gnt_sel;
                    alu_cmd_d = cmd_q[gnt_sel];
                    alu_op1_d = op1_q[gnt_sel];
                    alu_op2_d = (pst_q[gnt_sel] == POp2) ? data_in[gnt_sel] : op2_q[gnt_sel];
                end
            end
            SReq: begin
                if (alu_ready) begin
                    sst_d = SWait;
                    ptr_d = gnt_q + 2'd1;
`ifdef CALC1_SCHED_TIMEOUT_EN
                    tmo_d = 32'd0;
`endif
                end
            end
            SWait: begin
                if (alu_done) begin
                    fin   = 1'b1;
                    sst_d = SIdle;
`ifdef CALC1_SCHED_TIMEOUT_EN
                end else if (tmo_q >= 32'(TIMEOUT_CYCLES - 1)) begin
                    fin      = 1'b1;
                    fin_resp = 2'd2;
                    fin_data = 32'd0;
                    sst_d    = SIdle;
                end else begin
                    tmo_d = tmo_q + 32'd1;
`endif
                end
            end
            default: sst_d = SIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pst_d[i]   = pst_q[i];
            cmd_d[i]   = cmd_q[i];
            op1_d[i]   = op1_q[i];
            op2_d[i]   = op2_q[i];
            resp_d[i]  = resp_q[i];
            rdata_d[i] = rdata_q[i];
            case (pst_q[i])
                PIdle: begin
                    if (cmd_in[i] != 4'd0) begin
                        pst_d[i] = POp2;
                        cmd_d[i] = cmd_in[i];
                        op1_d[i] = data_in[i];
                    end
                end
                POp2: begin
                    op2_d[i] = data_in[i];
                    if (cmd_is_valid(cmd_q[i])) begin
                        pst_d[i] = PPend;
                    end else begin
                        pst_d[i]   = PResp;
                        resp_d[i]  = 2'd2;
                        rdata_d[i] = 32'd0;
                    end
                end
                PPend: begin
                    if (fin && (gnt_q == 2'(i))) begin
                        pst_d[i]   = PResp;
                        resp_d[i]  = fin_resp;
                        rdata_d[i] = fin_data;
                    end
                end
                PResp:   pst_d[i] = PIdle;
                default: pst_d[i] = PIdle;
            endcase
            resp_out[i] = (pst_q[i] == PResp) ? resp_q[i] : 2'd0;
            data_out[i] = ((pst_q[i] == PResp) && (resp_q[i] != 2'd0)) ? rdata_q[i] : 32'd0;
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pst_q[i]   <= PIdle;
                cmd_q[i]   <= 4'd0;
                op1_q[i]   <= 32'd0;
                op2_q[i]   <= 32'd0;
                resp_q[i]  <= 2'd0;
                rdata_q[i] <= 32'd0;
            end
            sst_q     <= SIdle;
            gnt_q     <= 2'd0;
            ptr_q     <= 2'd0;
            alu_cmd_q <= 4'd0;
            alu_op1_q <= 32'd0;
            alu_op2_q <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pst_q[i]   <= pst_d[i];
                cmd_q[i]   <= cmd_d[i];
                op1_q[i]   <= op1_d[i];
                op2_q[i]   <= op2_d[i];
                resp_q[i]  <= resp_d[i];
                rdata_q[i] <= rdata_d[i];
            end
            sst_q     <= sst_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            alu_cmd_q <= alu_cmd_d;
            alu_op1_q <= alu_op1_d;
            alu_op2_q <= alu_op2_d;
        end
    end

`ifdef CALC1_SCHED_TIMEOUT_EN
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign alu_valid = (sst_q == SReq);
    assign alu_cmd   = alu_cmd_q;
    assign alu_op1   = alu_op1_q;
    assign alu_op2   = alu_op2_q;

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Directed bench for calc1_port_scheduler with a small delayed-done ALU model.
// The timeout sequence is compiled only with CALC1_SCHED_TIMEOUT_EN.
module tb_calc1_port_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd [4];
    logic [31:0] dat [4];
    wire  [1:0]  resp [4];
    wire  [31:0] odat [4];
    wire         alu_valid;
    logic        alu_ready = 1'b1;
    wire  [3:0]  alu_cmd;
    wire  [31:0] alu_op1;
    wire  [31:0] alu_op2;
    logic        alu_done = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [1:0]  alu_resp = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ALU model: done pulse m_delay edges after accept, unless m_never is set.
    int          m_delay = 3;
    bit          m_never = 1'b0;
    logic [1:0]  m_resp  = 2'd1;
    bit          m_busy  = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_res   = 32'd0;
    int          acc_cnt = 0;
    logic [31:0] acc_log [16];

    calc1_port_scheduler #(.TIMEOUT_CYCLES(8)) dut (
        .c_clk       (clk),
        .reset       (reset),
        .req1_cmd_in (cmd[0]),
        .req2_cmd_in (cmd[1]),
        .req3_cmd_in (cmd[2]),
        .req4_cmd_in (cmd[3]),
        .req1_data_in(dat[0]),
        .req2_data_in(dat[1]),
        .req3_data_in(dat[2]),
        .req4_data_in(dat[3]),
        .out_resp1   (resp[0]),
        .out_resp2   (resp[1]),
        .out_resp3   (resp[2]),
        .out_resp4   (resp[3]),
        .out_data1   (odat[0]),
        .out_data2   (odat[1]),
        .out_data3   (odat[2]),
        .out_data4   (odat[3]),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_cmd     (alu_cmd),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .alu_resp    (alu_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (m_busy) begin
            if (m_cnt <= 1) begin
                if (!m_never) begin
                    alu_done   <= 1'b1;
                    alu_result <= m_res;
                    alu_resp   <= m_resp;
                end
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (alu_valid && alu_ready) begin
            m_busy                <= 1'b1;
            m_cnt                 <= m_delay;
            m_res                 <= alu_fn(alu_cmd, alu_op1, alu_op2);
            acc_log[acc_cnt % 16] <= alu_op1;
            acc_cnt               <= acc_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int others_nonzero(input int p);
        int n = 0;
        for (int q = 0; q < 4; q++) begin
            if (q != p && (resp[q] != 2'd0 || odat[q] != 32'd0)) n++;
        end
        return n;
    endfunction

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  mresp;
        bit          uses_alu;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input vec_t v);
        int a0 = acc_cnt;
        int dcyc = -100;
        bit got = 1'b0;
        m_resp = v.mresp;
        cmd[v.port] = v.cmd;
        dat[v.port] = v.op1;
        tick();
        cmd[v.port] = 4'd0;
        dat[v.port] = v.op2;
        tick();
        dat[v.port] = 32'd0;
        if (!v.uses_alu) begin
            chk("inv_resp_c2", resp[v.port], v.exp_resp);
            chk("inv_data_c2", odat[v.port], v.exp_data);
            chk("inv_no_valid", alu_valid, 1'b0);
        end else begin
            chk("valid_c2", alu_valid, 1'b1);
            for (int k = 0; k < 40 && !got; k++) begin
                tick();
                if (alu_done) dcyc = cyc;
                if (resp[v.port] != 2'd0) got = 1'b1;
            end
            chk("resp_seen", got, 1'b1);
            chk("resp_code", resp[v.port], v.exp_resp);
            chk("resp_data", odat[v.port], v.exp_data);
            chk("resp_after_done", cyc, dcyc + 1);
        end
        chk("other_ports_quiet", others_nonzero(v.port), 0);
        tick();
        chk("resp_one_cycle", resp[v.port], 2'd0);
        chk("accept_count", acc_cnt - a0, v.uses_alu ? 1 : 0);
    endtask

    // All four ports issue add together; grants rotate starting at port index 'first'.
    task automatic all_four(input int first);
        int a0 = acc_cnt;
        int nresp = 0;
        int rord [4];
        m_delay = 3;
        m_resp  = 2'd1;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd1;
            dat[p] = 32'h11 * (p + 1);
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            dat[p] = 32'h100;
        end
        tick();
        for (int p = 0; p < 4; p++) dat[p] = 32'd0;
        for (int t = 0; t < 200 && nresp < 4; t++) begin
            for (int p = 0; p < 4; p++) begin
                if (resp[p] != 2'd0) begin
                    chk("all4_resp", resp[p], 2'd1);
                    chk("all4_data", odat[p], 32'h100 + 32'h11 * (p + 1));
                    if (nresp < 4) rord[nresp] = p;
                    nresp++;
                end
            end
            if (nresp < 4) tick();
        end
        chk("all4_count", nresp, 4);
        for (int k = 0; k < 4; k++) begin
            chk("all4_grant_order", acc_log[(a0 + k) % 16], 32'h11 * (((first + k) % 4) + 1));
            chk("all4_resp_order", rord[k], (first + k) % 4);
        end
        tick();
    endtask

    initial begin
        int a0;
        int nz;
        int dn;
        int c1;
        bit got;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0;
            dat[p] = 32'd0;
        end
        vecs[0] = '{0, 4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 1'b1, 2'd1, 32'h20000000};
        vecs[1] = '{1, 4'd2, 32'd10,       32'd3,        2'd1, 1'b1, 2'd1, 32'd7};
        vecs[2] = '{2, 4'd5, 32'd1,        32'd4,        2'd1, 1'b1, 2'd1, 32'h10};
        vecs[3] = '{3, 4'd6, 32'h80000000, 32'd31,       2'd1, 1'b1, 2'd1, 32'd1};
        vecs[4] = '{2, 4'd4, 32'h00008000, 32'd0,        2'd1, 1'b0, 2'd2, 32'd0};
        vecs[5] = '{1, 4'd1, 32'h80000000, 32'h80000000, 2'd2, 1'b1, 2'd2, 32'd0};
        vecs[6] = '{0, 4'd3, 32'h12345678, 32'd1,        2'd1, 1'b0, 2'd2, 32'd0};
        vecs[7] = '{3, 4'd15, 32'hDEADBEEF, 32'd2,       2'd1, 1'b0, 2'd2, 32'd0};
        vecs[8] = '{1, 4'd7, 32'd5,        32'd6,        2'd1, 1'b0, 2'd2, 32'd0};
        vecs[9] = '{3, 4'd1, 32'hFFFFFFFF, 32'd2,        2'd1, 1'b1, 2'd1, 32'd1};

        tick();
        nz = 0;
        for (int p = 0; p < 4; p++) if (resp[p] != 2'd0 || odat[p] != 32'd0) nz++;
        chk("rst_port_outputs", nz, 0);
        chk("rst_alu_valid", alu_valid, 1'b0);
        chk("rst_alu_cmd", alu_cmd, 4'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_op2", alu_op2, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        do_reset();
        all_four(0);

        // Port 2 overflow with ready stalled; a second command while pending is dropped.
        m_delay   = 6;
        m_resp    = 2'd2;
        a0        = acc_cnt;
        cmd[1]    = 4'd1;
        dat[1]    = 32'h80000000;
        tick();
        cmd[1]    = 4'd0;
        alu_ready = 1'b0;
        tick();
        cmd[1] = 4'd1;
        dat[1] = 32'd5;
        for (int k = 0; k < 3; k++) begin
            chk("stall_valid_held", alu_valid, 1'b1);
            chk("stall_op1_held", alu_op1, 32'h80000000);
            chk("stall_op2_held", alu_op2, 32'h80000000);
            tick();
            cmd[1] = 4'd0;
            dat[1] = 32'd6;
        end
        dat[1]    = 32'd0;
        alu_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            tick();
            if (resp[1] != 2'd0) got = 1'b1;
        end
        chk("ovf_resp", resp[1], 2'd2);
        chk("ovf_data", odat[1], 32'd0);
        nz = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (resp[1] != 2'd0) nz++;
        end
        chk("dropped_no_resp", nz, 0);
        chk("dropped_no_accept", acc_cnt - a0, 1);

        // Pointer now sits after port 2, so rotation starts at port 3.
        all_four(2);

        // Reset during S_WAIT: immediate clear, later alu_done ignored.
        m_delay = 6;
        m_resp  = 2'd1;
        a0      = acc_cnt;
        cmd[0]  = 4'd1;
        dat[0]  = 32'd7;
        tick();
        cmd[0] = 4'd0;
        dat[0] = 32'd8;
        tick();
        dat[0] = 32'd0;
        for (int t = 0; t < 20 && acc_cnt == a0; t++) tick();
        chk("rstw_accept", acc_cnt - a0, 1);
        chk("rstw_op1_before", alu_op1, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_op1_async", alu_op1, 32'd0);
        chk("rstw_cmd_async", alu_cmd, 4'd0);
        chk("rstw_valid_async", alu_valid, 1'b0);
        tick();
        reset = 1'b0;
        nz = 0;
        dn = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if (alu_done) dn++;
            for (int p = 0; p < 4; p++) if (resp[p] != 2'd0) nz++;
        end
        chk("rstw_late_done_seen", dn, 1);
        chk("rstw_late_done_ignored", nz, 0);

        // Reset during a response cycle clears it asynchronously.
        cmd[2] = 4'd4;
        dat[2] = 32'h8000;
        tick();
        cmd[2] = 4'd0;
        dat[2] = 32'd0;
        tick();
        chk("rstr_resp_before", resp[2], 2'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("rstr_resp_async", resp[2], 2'd0);
        tick();
        reset = 1'b0;
        tick();

`ifdef CALC1_SCHED_TIMEOUT_EN
        do_reset();
        m_never = 1'b1;
        m_delay = 3;
        a0      = acc_cnt;
        cmd[3]  = 4'd1;
        dat[3]  = 32'h44;
        tick();
        cmd[3] = 4'd0;
        dat[3] = 32'd1;
        cmd[0] = 4'd1;
        dat[0] = 32'h55;
        tick();
        c1 = cyc;
        chk("tmo_valid_c2", alu_valid, 1'b1);
        cmd[0] = 4'd0;
        dat[0] = 32'd2;
        dat[3] = 32'd0;
        tick();
        dat[0] = 32'd0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (resp[3] != 2'd0) got = 1'b1;
            else tick();
        end
        chk("tmo_resp", resp[3], 2'd2);
        chk("tmo_data", odat[3], 32'd0);
        chk("tmo_latency", cyc, c1 + 9);
        for (int t = 0; t < 40 && (acc_cnt - a0) < 2; t++) tick();
        chk("tmo_next_grant_count", acc_cnt - a0, 2);
        chk("tmo_next_grant_port1", acc_log[(a0 + 1) % 16], 32'h55);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc1_port_scheduler.md
# calc1_port_scheduler

Four-port front-end scheduler that shares a single calc1 arithmetic unit between the four requester ports. Each port issues two-cycle requests (command plus operand 1, then operand 2). The scheduler captures one outstanding request per port and grants the shared unit round-robin over a valid/ready/done handshake. It returns a one-cycle response on that port's output pair and sits between the port pins and the shared ALU inside the calc1 top level.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles from ALU accept to `alu_done` (used only with `CALC1_SCHED_TIMEOUT_EN`).
- `c_clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req1_cmd_in`..`req4_cmd_in` in [0:3] each: port command. 0 = no-op, 1 = add, 2 = sub, 5 = shift left, 6 = shift right.
- `req1_data_in`..`req4_data_in` in [0:31] each: operand 1 in the command cycle, operand 2 in the following cycle.
- `out_resp1`..`out_resp4` out [0:1] each: 0 = none, 1 = success, 2 = overflow/underflow/invalid/timeout, 3 = never driven.
- `out_data1`..`out_data4` out [0:31] each: result; valid only while the matching `out_respN` != 0, else 0.
- `alu_valid` out 1: request to the shared unit.
- `alu_ready` in 1: the unit accepts when `alu_valid && alu_ready`.
- `alu_cmd` out [0:3], `alu_op1` out [0:31], `alu_op2` out [0:31]: operands; held stable while `alu_valid`.
- `alu_done` in 1: one-cycle completion pulse.
- `alu_result` in [0:31], `alu_resp` in [0:1]: sampled when `alu_done` is high.

## Operation
- Per-port FSM states:
  - IDLE: nonzero cmd → OP2, latching cmd and operand 1.
  - OP2: latch operand 2. Valid cmd → PEND. Invalid cmd (3, 4, 7..15) → RESP with code 2, data 0, without using the ALU.
  - PEND: waiting for grant.
  - RESP: drives the response for one cycle, then returns to IDLE.
- A port that is not in IDLE ignores its cmd/data inputs; those requests are dropped with no response.
- Scheduler FSM states:
  - S_IDLE: any port in PEND → S_REQ; the grant goes to the first pending port at or after the round-robin pointer.
  - S_REQ: `alu_valid`=1; on `alu_ready` → S_WAIT.
  - S_WAIT: on `alu_done`, copy `alu_resp`/`alu_result` to the granted port (→ RESP) and go to S_IDLE. `alu_done` is ignored in any other state.
- Round-robin pointer: resets to port 1; on each accept it moves to the port after the granted one (4 wraps to 1).
- At most one operation is in flight; operand width is fixed at 32 bits; the scheduler does not modify `alu_resp` or `alu_result`.

## Timing
- Reset values:
  - All `out_respN`/`out_dataN` = 0.
  - `alu_valid` = 0; `alu_cmd`/`alu_op1`/`alu_op2` = 0.
  - All FSMs idle; pointer = port 1.
- Cycle 0: cmd + op1 sampled. Cycle 1: op2 sampled. Cycle 2: earliest `alu_valid`.
- Idle unit with `alu_ready`=1 and `alu_done` in cycle k: `out_respN` is nonzero in cycle k+1 for exactly one cycle.
- Invalid cmd: response in cycle 2.
- A port may issue a new cmd in the cycle after its RESP cycle.
- The cycle in which the scheduler returns to S_IDLE may re-grant, so back-to-back operations leave no idle gap.
- Simultaneous PEND on all ports after reset: grant order is 1, 2, 3, 4.
- Reset asserted mid-operation: outputs clear immediately (asynchronously); any late `alu_done` is ignored.

## Configuration
- `CALC1_SCHED_TIMEOUT_EN` defined: a counter starts at ALU accept.
  - If `alu_done` has not arrived after `TIMEOUT_CYCLES` cycles, the granted port gets resp 2, data 0, and the scheduler returns to S_IDLE.
  - A subsequent stray `alu_done` is ignored.
- Not defined: no counter; S_WAIT waits indefinitely.

## Test plan
- Port 1: add 0x00000001 + 0x1FFFFFFF; ALU model with done 3 cycles after accept returning resp 1, data 0x20000000 → `out_resp1`=1 and `out_data1`=0x20000000 for one cycle; all other ports stay 0.
- Ports 1–4 issue add in the same cycle → `alu_valid` grants in order 1, 2, 3, 4, with each response on its own port and no cross-port data.
- Port 3 issues cmd 4 with op 0x8000 → `out_resp3`=2 and `out_data3`=0 in cycle 2; `alu_valid` never asserts.
- Port 2: add 0x80000000 + 0x80000000 with the model returning resp 2 → `out_resp2`=2; a second cmd on port 2 while pending is dropped.
- Reset pulsed while in S_WAIT → all outputs 0 immediately; a later `alu_done` produces no response.
- `CALC1_SCHED_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8 and a model that never raises done → port 4 gets resp 2 after 8 cycles, and the next pending port is then granted.
